pll_lock_supervisor: RTL and testbench



---
 rtl/pll_supervisor_pkg.sv | 22 ++
 rtl/pll_lock_supervisor_lock_sync.sv | 34 +++
 rtl/pll_lock_supervisor.sv | 235 +++++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_supervisor_pkg
// Shared types and width constants for the PLL lock supervisor.
//   sup_state_e : supervisor FSM states
//   RetryW      : width of the retry_count output
//   LossCntW    : width of the lock_loss_count output
// -----------------------------------------------------------------------------
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRelease,
        StRun,
        StFault
    } sup_state_e;

    localparam int unsigned RetryW   = 4;
    localparam int unsigned LossCntW = 8;

endpackage

// File: rtl/pll_lock_supervisor_lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// Generic 2-FF synchroniser with synchronous active-high reset to 0.
// Ports:
//   clock   : destination clock
//   reset   : synchronous, active-high; clears both stages
//   async_i : asynchronous input
//   sync_o  : input re-timed to clock (2 cycles of latency)
// -----------------------------------------------------------------------------
module lock_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] async_i,
    output logic [Width-1:0] sync_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Supervises an EHXPLLL clock tree from the reference clock: pulses the PLL
// reset, waits for a stable synchronised lock (retrying on timeout), then
// releases the downstream domain resets in a staggered order. Lock loss or a
// relock request pulls every domain back into reset and re-runs the sequence.
//
// Optional feature macro: PLL_SUPERVISOR_STATS_EN
//   defined   -> lock_loss_count counts lock-loss events, saturating at 255
//   undefined -> lock_loss_count is tied to 0
//
// Ports:
//   clock           : reference clock
//   reset           : synchronous, active-high
//   pll_locked      : raw PLL LOCK (asynchronous)
//   relock_req      : single-cycle request to restart the sequence
//   lock_lost_clr   : clears the sticky lock_lost flag
//   pll_rst         : to EHXPLLL RST
//   domain_rst      : per-domain active-high reset, bit 0 released first
//   all_ready       : high only while every domain is running
//   fault           : high only after retries are exhausted
//   retry_count     : failed attempts since the last RUN entry or FAULT exit
//   lock_lost       : sticky, set on lock loss after release began
//   lock_loss_count : lock-loss event counter (see macro above)
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS         = 4,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned DOMAIN_STAGGER      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   relock_req,
    input  logic                   lock_lost_clr,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_ready,
    output logic                   fault,
    output logic [RetryW-1:0]      retry_count,
    output logic                   lock_lost,
    output logic [LossCntW-1:0]    lock_loss_count
);

    // Span from domain_rst[0] falling to the last bit falling.
    localparam int unsigned RelSpan = (NUM_DOMAINS - 1) * DOMAIN_STAGGER;

    // One counter serves every timed state, so size it for the longest.
    localparam int unsigned CntMaxA = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CntMaxB = (LOCK_TIMEOUT_CYCLES > CntMaxA) ?
                                      LOCK_TIMEOUT_CYCLES : CntMaxA;
    localparam int unsigned CntMax  = (RelSpan > CntMaxB) ? RelSpan : CntMaxB;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] RelLast     = CntW'(RelSpan);

    logic lock_s;

    lock_sync #(
        .Width (1)
    ) u_lock_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (pll_locked),
        .sync_o  (lock_s)
    );

    sup_state_e             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [RetryW-1:0]      retry_q, retry_d;
    logic                   lost_q, lost_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_loss;
    logic [31:0]            rel_elapsed;

    // Lock loss only matters once domain release has begun.
    assign lock_loss = ((state_q == StRelease) || (state_q == StRun)) && !lock_s;
    assign cnt_inc   = cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        if (lock_lost_clr) begin
            lost_d = 1'b0;
        end

        unique case (state_q)
            StResetPll: begin
                if (cnt_q >= RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    // The locked cycle that ends the wait already counts.
                    state_d = StStable;
                    cnt_d   = CntW'(1);
                end else if (cnt_q >= TimeoutLast) begin
                    cnt_d = '0;
                    if (retry_q < RetryW'(MAX_RETRIES)) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StResetPll;
                    end else begin
                        state_d = StFault;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q >= StableLast) begin
                    cnt_d = '0;
                    if (RelSpan == 0) begin
                        state_d = StRun;
                        retry_d = '0;
                    end else begin
                        state_d = StRelease;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRelease, StRun: begin
                if (lock_loss) begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end else if (relock_req) begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                end else if (state_q == StRelease) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= RelLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end
            end
            StFault: begin
                if (relock_req) begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StResetPll;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        pll_rst_d   = (state_d == StResetPll);
        ready_d     = (state_d == StRun);
        fault_d     = (state_d == StFault);
        rel_elapsed = 32'(cnt_d);
        dom_d       = '1;
        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            if (state_d == StRun) begin
                dom_d[k] = 1'b0;
            end else if (state_d == StRelease) begin
                dom_d[k] = (rel_elapsed < k * DOMAIN_STAGGER);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StResetPll;
            cnt_q     <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

`ifdef PLL_SUPERVISOR_STATS_EN
    logic [LossCntW-1:0] loss_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else if (lock_loss && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + LossCntW'(1);
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = '0;
`endif

    assign pll_rst     = pll_rst_q;
    assign domain_rst  = dom_q;
    assign all_ready   = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign lock_lost   = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed scenarios followed by a randomised run. A behavioural model tracks
// the supervisor as phases with elapsed-time and lock-streak bookkeeping and
// every output is compared after each clock edge, plus directed spot checks.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int ND   = 3;
    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int LTC  = 32;
    localparam int MR   = 2;
    localparam int DS   = 2;
    localparam int Span = (ND - 1) * DS;

`ifdef PLL_SUPERVISOR_STATS_EN
    localparam int ExpLoss1 = 1;
    localparam bit StatsEn  = 1'b1;
`else
    localparam int ExpLoss1 = 0;
    localparam bit StatsEn  = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          lock_lost_clr = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] domain_rst;
    logic          all_ready;
    logic          fault;
    logic [3:0]    retry_count;
    logic          lock_lost;
    logic [7:0]    lock_loss_count;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .NUM_DOMAINS         (ND),
        .PLL_RST_CYCLES      (PRC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .MAX_RETRIES         (MR),
        .DOMAIN_STAGGER      (DS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .relock_req      (relock_req),
        .lock_lost_clr   (lock_lost_clr),
        .pll_rst         (pll_rst),
        .domain_rst      (domain_rst),
        .all_ready       (all_ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_lost       (lock_lost),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef enum int {PhPllReset, PhAwait, PhQualify, PhStagger, PhRunning, PhDead} phase_t;

    phase_t m_phase  = PhPllReset;
    int     m_age    = 1;   // cycles spent in the current phase, this one included
    int     m_streak = 0;   // consecutive synchronised-lock cycles seen
    int     m_rel    = 0;   // cycles since domain 0 was released
    int     m_retry  = 0;
    bit     m_lost   = 1'b0;
    int     m_losses = 0;
    bit     m_pipe[2] = '{1'b0, 1'b0};  // synchroniser pipe, [1] is what the FSM sees

    task automatic enter_reset();
        m_phase = PhPllReset;
        m_age   = 1;
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_edge();
        bit seen;
        bit loss;
        seen = m_pipe[1];
        if (reset) begin
            m_pipe   = '{1'b0, 1'b0};
            m_retry  = 0;
            m_lost   = 1'b0;
            m_losses = 0;
            enter_reset();
            return;
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = pll_locked;
        loss = ((m_phase == PhStagger) || (m_phase == PhRunning)) && !seen;
        if (loss) m_lost = 1'b1;
        else if (lock_lost_clr) m_lost = 1'b0;
        case (m_phase)
            PhPllReset: begin
                if (m_age == PRC) begin m_phase = PhAwait; m_age = 1; end
                else m_age++;
            end
            PhAwait: begin
                if (seen) begin
                    m_phase = PhQualify;
                    m_streak = 1;
                end else if (m_age == LTC) begin
                    if (m_retry < MR) begin m_retry++; enter_reset(); end
                    else m_phase = PhDead;
                end else m_age++;
            end
            PhQualify: begin
                if (!seen) begin m_phase = PhAwait; m_age = 1; end
                else begin
                    m_streak++;
                    if (m_streak >= LSC) begin
                        m_rel = 0;
                        if (Span == 0) begin m_phase = PhRunning; m_retry = 0; end
                        else m_phase = PhStagger;
                    end
                end
            end
            PhStagger, PhRunning: begin
                if (loss) begin
                    if (m_losses < 255) m_losses++;
                    enter_reset();
                end else if (relock_req) begin
                    enter_reset();
                end else if (m_phase == PhStagger) begin
                    m_rel++;
                    if (m_rel >= Span) begin m_phase = PhRunning; m_retry = 0; end
                end
            end
            PhDead: begin
                if (relock_req) begin m_retry = 0; enter_reset(); end
            end
            default: enter_reset();
        endcase
    endtask

    function automatic logic [ND-1:0] exp_dom();
        logic [ND-1:0] v;
        for (int k = 0; k < ND; k++) begin
            if (m_phase == PhRunning) v[k] = 1'b0;
            else if (m_phase == PhStagger) v[k] = (m_rel < k * DS);
            else v[k] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pll_rst", 32'(pll_rst), 32'(m_phase == PhPllReset));
        chk("domain_rst", 32'(domain_rst), 32'(exp_dom()));
        chk("all_ready", 32'(all_ready), 32'(m_phase == PhRunning));
        chk("fault", 32'(fault), 32'(m_phase == PhDead));
        chk("retry_count", 32'(retry_count), 32'(m_retry));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk("lock_loss_count", 32'(lock_loss_count), StatsEn ? 32'(m_losses) : 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int width;
        bit found;

        // Nominal bring-up with the PLL locked from reset release.
        reset = 1'b1;
        pll_locked = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        width = int'(pll_rst);
        for (int i = 0; i < 12; i++) begin
            step();
            if (pll_rst) width++;
        end
        chk("pll_rst_width", 32'(width), 32'(PRC));
        repeat (30) step();
        chk("nominal_ready", 32'(all_ready), 32'd1);
        chk("nominal_dom", 32'(domain_rst), 32'd0);
        chk("nominal_retry", 32'(retry_count), 32'd0);

        // One-cycle lock drop in RUN: visible three edges later.
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        chk("loss_not_yet", 32'(all_ready), 32'd1);
        step();
        chk("loss_dom", 32'(domain_rst), 32'h7);
        chk("loss_ready", 32'(all_ready), 32'd0);
        chk("loss_flag", 32'(lock_lost), 32'd1);
        repeat (40) step();
        chk("reseq_ready", 32'(all_ready), 32'd1);
        chk("loss_count", 32'(lock_loss_count), 32'(ExpLoss1));
        lock_lost_clr = 1'b1;
        step();
        lock_lost_clr = 1'b0;
        chk("lost_cleared", 32'(lock_lost), 32'd0);

        // relock_req in RUN re-sequences without touching lock_lost.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk("relock_dom", 32'(domain_rst), 32'h7);
        repeat (40) step();
        chk("relock_ready", 32'(all_ready), 32'd1);
        chk("relock_lost", 32'(lock_lost), 32'd0);

        // Unstable lock: 5 locked cycles, one drop, then locked again.
        pll_locked = 1'b0;
        repeat (6) step();
        pll_locked = 1'b1;
        repeat (5) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        repeat (6) step();
        chk("unstable_held", 32'(domain_rst), 32'h7);
        repeat (30) step();
        chk("unstable_ready", 32'(all_ready), 32'd1);
        chk("unstable_retry", 32'(retry_count), 32'd0);

        // Reset while partway through the staggered release.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (m_phase == PhStagger && exp_dom() == 3'b110) found = 1'b1;
        end
        chk("find_release", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_pll_rst", 32'(pll_rst), 32'd1);
        chk("midreset_dom", 32'(domain_rst), 32'h7);
        chk("midreset_ready", 32'(all_ready), 32'd0);
        repeat (40) step();

        // Lock loss and lock_lost_clr in the same cycle: set wins.
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        lock_lost_clr = 1'b1;
        step();
        lock_lost_clr = 1'b0;
        chk("loss_vs_clr", 32'(lock_lost), 32'd1);
        repeat (40) step();

        // Timeout path: three failed attempts end in FAULT.
        pll_locked = 1'b0;
        repeat (130) step();
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_retry", 32'(retry_count), 32'd2);
        chk("fault_pll_rst", 32'(pll_rst), 32'd0);
        chk("fault_dom", 32'(domain_rst), 32'h7);
        pll_locked = 1'b1;
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk("fault_exit", 32'(fault), 32'd0);
        chk("fault_exit_retry", 32'(retry_count), 32'd0);
        repeat (40) step();
        chk("fault_recover", 32'(all_ready), 32'd1);

        // Randomised run against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
            relock_req    = ($urandom_range(0, 99) == 0);
            lock_lost_clr = ($urandom_range(0, 29) == 0);
            reset         = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        relock_req = 1'b0;
        lock_lost_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
